alu_rr_scheduler: RTL and testbench

Shares one 4-function ALU datapath (XOR, shift-left, modulo, NAND) between NREQ requesters.
- Arbitrates round-robin among the requesters.
- Computes the result with one cycle of latency into a single-entry output register.
- Returns the result, tagged with its source, over a valid/ready handshake.
- Sits between the request agents and the downstream result consumer.

---
 rtl/alu_sched_pkg.sv | 54 +++++
 rtl/rr_arbiter.sv | 59 +++++
 rtl/alu_rr_scheduler.sv | 110 +++++++++++
 tb/tb_alu_rr_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and the ALU function for the round-robin ALU scheduler.
//   alu_op_e  : 2-bit opcode (XOR, shift-left, modulo, NAND)
//   result_t  : {data, src, err} result record
//   alu_eval  : evaluates one operation at a given operand width; the
//               result data is already masked to that width.
package alu_sched_pkg;

    // Widest operand the shared function supports; callers zero-extend.
    localparam int ALU_MAX_W = 64;
    localparam int SRC_MAX_W = 3;

    typedef enum logic [1:0] {
        OP_XOR  = 2'd0,
        OP_SHL  = 2'd1,
        OP_MOD  = 2'd2,
        OP_NAND = 2'd3
    } alu_op_e;

    typedef struct packed {
        logic [ALU_MAX_W-1:0] data;
        logic [SRC_MAX_W-1:0] src;
        logic                 err;
    } result_t;

    // src is left at zero; the caller tags the result with its requester.
    function automatic result_t alu_eval(
        input alu_op_e              op,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b,
        input int unsigned          w
    );
        result_t              r;
        logic [ALU_MAX_W-1:0] one;
        logic [ALU_MAX_W-1:0] mask;
        one  = {{(ALU_MAX_W-1){1'b0}}, 1'b1};
        mask = (w >= ALU_MAX_W) ? '1 : ((one << w) - one);
        r    = '0;
        case (op)
            OP_XOR:  r.data = (a ^ b) & mask;
            OP_SHL:  r.data = (b >= ALU_MAX_W'(w)) ? '0 : ((a << b) & mask);
            OP_MOD: begin
                if (b == '0) begin
                    r.data = a & mask;
                    r.err  = 1'b1;
                end else begin
                    r.data = (a % b) & mask;
                end
            end
            default: r.data = ~(a & b) & mask;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, rst   : clock, synchronous active-high reset (pointer -> 0)
//   req        : per-requester request
//   advance    : grant was taken this cycle; pointer moves past the winner
//   grant_oh   : one-hot winner (all zero when no request)
//   grant_idx  : winner index
//   any_valid  : at least one request present
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             advance,
    output logic [NREQ-1:0]  grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_valid
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        int j;
        j         = 0;
        grant_oh  = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        // Walk ptr, ptr+1, ... wrapping at NREQ; first request wins.
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any_valid && req[j]) begin
                any_valid   = 1'b1;
                grant_oh[j] = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one 4-function ALU between NREQ requesters with round-robin
// arbitration and a single-entry output register (1-cycle latency).
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake, at most one ready high
//   req_op/req_a/req_b    : packed per-requester opcode and operands
//   out_valid/out_ready   : result handshake to the consumer
//   out_data/out_src      : result and index of the requester it came from
//   out_err               : result came from a modulo by zero
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREQ   = 2,
    parameter int SRC_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [DATA_W*NREQ-1:0]   req_a,
    input  logic [DATA_W*NREQ-1:0]   req_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SRC_W-1:0]         out_src,
    output logic                     out_err
);

    logic [NREQ-1:0]   grant_oh;
    logic [SRC_W-1:0]  grant_idx;
    logic              any_valid;
    logic              can_accept;
    logic              accept;
    alu_op_e           sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    result_t           alu_res;
    logic              unused_alu;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SRC_W-1:0]  out_src_q,   out_src_d;
    logic              out_err_q,   out_err_d;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (SRC_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (accept),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    // Ready is held low during reset so no requester sees a handshake
    // that the reset is about to discard.
    always_comb begin
        can_accept = !out_valid_q || out_ready;
        accept     = any_valid && can_accept && !rst;
        req_ready  = accept ? grant_oh : '0;
    end

    always_comb begin
        sel_op     = alu_op_e'(req_op[grant_idx*2 +: 2]);
        sel_a      = req_a[grant_idx*DATA_W +: DATA_W];
        sel_b      = req_b[grant_idx*DATA_W +: DATA_W];
        alu_res    = alu_eval(sel_op, ALU_MAX_W'(sel_a), ALU_MAX_W'(sel_b), DATA_W);
        unused_alu = ^{alu_res.data[ALU_MAX_W-1:DATA_W], alu_res.src};
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_err_d   = out_err_q;
        if (accept) begin
            // Covers the simultaneous drain+accept case: overwrite, stay valid.
            out_valid_d = 1'b1;
            out_data_d  = alu_res.data[DATA_W-1:0];
            out_src_d   = grant_idx;
            out_err_d   = alu_res.err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed testbench for alu_rr_scheduler (DATA_W=8, NREQ=2).
// Inputs are driven just after the falling edge; outputs are sampled
// 1 time unit later, well away from the rising edge.
module tb_alu_rr_scheduler;

    localparam int DATA_W = 8;
    localparam int NREQ   = 2;
    localparam int SRC_W  = 1;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [2*NREQ-1:0]      req_op;
    logic [DATA_W*NREQ-1:0] req_a;
    logic [DATA_W*NREQ-1:0] req_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic [SRC_W-1:0]       out_src;
    logic                   out_err;

    int vectors    = 0;
    int miscompares = 0;

    alu_rr_scheduler #(
        .DATA_W (DATA_W),
        .NREQ   (NREQ),
        .SRC_W  (SRC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*i +: 2] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
            vectors++;
            if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", req_ready); end
            vectors++;
            if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", out_data); end
            vectors++;
            if (out_src !== 1'b0 || out_err !== 1'b0) begin miscompares++; $display("FAIL reset_src_err: got src=%b err=%b want 0/0", out_src, out_err); end
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || req_ready !== 2'b00) begin miscompares++; $display("FAIL idle: got valid=%b ready=%b want 0/00", out_valid, req_ready); end
    endtask

    task automatic test_single;
        set_req(0, 2'd2, 8'd23, 8'd5);
        req_valid = 2'b01;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin miscompares++; $display("FAIL single_ready: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", out_valid); end
        vectors++;
        if (out_data !== 8'd3 || out_src !== 1'b0 || out_err !== 1'b0) begin
            miscompares++; $display("FAIL single_result: got data=%0d src=%b err=%b want 3/0/0", out_data, out_src, out_err);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'd3) begin
            miscompares++; $display("FAIL single_drain: got valid=%b data=%0d want 0/3", out_valid, out_data);
        end
    endtask

    task automatic test_contention;
        logic [1:0] exp_ready;
        logic [7:0] exp_data;
        rst = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 2'd0, 8'hF0, 8'h0F);
        set_req(1, 2'd3, 8'hFF, 8'h0F);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
            vectors++;
            if (req_ready !== exp_ready) begin miscompares++; $display("FAIL contention_grant[%0d]: got %b want %b", k, req_ready, exp_ready); end
            if (k > 0) begin
                exp_data = ((k - 1) % 2 == 0) ? 8'hFF : 8'hF0;
                vectors++;
                if (out_valid !== 1'b1 || out_data !== exp_data || out_src !== 1'((k - 1) % 2)) begin
                    miscompares++;
                    $display("FAIL contention_out[%0d]: got v=%b data=%h src=%b want 1/%h/%0d", k, out_valid, out_data, out_src, exp_data, (k - 1) % 2);
                end
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hF0 || out_src !== 1'b1) begin
            miscompares++; $display("FAIL contention_last: got v=%b data=%h src=%b want 1/f0/1", out_valid, out_data, out_src);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL contention_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        set_req(1, 2'd0, 8'h12, 8'h34);
        req_valid = 2'b10;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_first_ready: got %b want 10", req_ready); end
        @(negedge clk);
        set_req(1, 2'd3, 8'hAA, 8'h0F);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b want 00", c, req_ready); end
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'h26 || out_src !== 1'b1) begin
                miscompares++; $display("FAIL bp_hold[%0d]: got v=%b data=%h src=%b want 1/26/1", c, out_valid, out_data, out_src);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_release_ready: got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hF5 || out_src !== 1'b1) begin
            miscompares++; $display("FAIL bp_overwrite: got v=%b data=%h src=%b want 1/f5/1", out_valid, out_data, out_src);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_edge_arith;
        logic [1:0] ops  [7] = '{2'd1,  2'd1,  2'd2,  2'd2,  2'd1,  2'd3,  2'd2};
        logic [7:0] av   [7] = '{8'h81, 8'h5A, 8'd77, 8'd9,  8'hFF, 8'hF0, 8'd200};
        logic [7:0] bv   [7] = '{8'd1,  8'd8,  8'd0,  8'd4,  8'd7,  8'h3C, 8'd7};
        logic [7:0] expd [7] = '{8'h02, 8'h00, 8'd77, 8'd1,  8'h80, 8'hCF, 8'd4};
        logic       expe [7] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
        out_ready = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            if (k < 7) begin
                set_req(0, ops[k], av[k], bv[k]);
                req_valid = 2'b01;
            end else begin
                req_valid = 2'b00;
            end
            #1;
            if (k < 7) begin
                vectors++;
                if (req_ready !== 2'b01) begin miscompares++; $display("FAIL arith_ready[%0d]: got %b want 01", k, req_ready); end
            end
            if (k > 0) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== expd[k-1] || out_err !== expe[k-1] || out_src !== 1'b0) begin
                    miscompares++;
                    $display("FAIL arith[%0d]: got v=%b data=%h err=%b src=%b want 1/%h/%b/0", k - 1, out_valid, out_data, out_err, out_src, expd[k-1], expe[k-1]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        set_req(0, 2'd0, 8'h03, 8'h05);
        set_req(1, 2'd0, 8'h0F, 8'h01);
        req_valid = 2'b01;
        out_ready = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rmid_ready: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || req_ready !== 2'b00) begin
            miscompares++; $display("FAIL rmid_held: got v=%b ready=%b want 1/00", out_valid, req_ready);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 2'b00) begin miscompares++; $display("FAIL rmid_rst_ready: got %b want 00", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 1'b0) begin
            miscompares++; $display("FAIL rmid_cleared: got v=%b data=%h src=%b want 0/00/0", out_valid, out_data, out_src);
        end
        vectors++;
        if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rmid_ptr: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h06 || out_src !== 1'b0) begin
            miscompares++; $display("FAIL rmid_first: got v=%b data=%h src=%b want 1/06/0", out_valid, out_data, out_src);
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_edge_arith();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
